segrw_init_seq: RTL

// - Initiator/consumer end of the segment read/write stream protocol: drives the addr, dataW and

---
 rtl/segrw_pkg.sv | 27 ++
 rtl/segrw_tok_slot.sv | 46 ++++
 rtl/segrw_init_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/segrw_pkg.sv
// Shared types and defaults for the segrw initiator: FSM state encoding,
// default widths and the width helper for the read-credit counter.
package segrw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    EOS,
    DRAIN,
    FIN
  } state_e;

  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 32;
  localparam int LW_DEF      = 8;
  localparam int MAX_OUT_DEF = 4;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/segrw_tok_slot.sv
// One output-stream token register: holds v/e/d until the consumer takes it and
// remembers that it was taken so the three streams of an op can be joined.
module segrw_tok_slot #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         load_e,
  input  logic [W-1:0] load_d,
  input  logic         b,
  output logic         v,
  output logic         e,
  output logic [W-1:0] d,
  output logic         taken
);

  logic taken_q;

  // A load always follows (or coincides with) the take of the previous token,
  // so it wins over the transfer branch.
  always_ff @(posedge clock) begin
    if (reset) begin
      v       <= 1'b0;
      e       <= 1'b0;
      taken_q <= 1'b0;
    end else if (load) begin
      v       <= 1'b1;
      e       <= load_e;
      taken_q <= 1'b0;
    end else if (v && !b) begin
      v       <= 1'b0;
      e       <= 1'b0;
      taken_q <= 1'b1;
    end
  end

  // NOTE: payload registers carry no reset; they are only observed while v=1.
  always_ff @(posedge clock) begin
    if (load) d <= load_d;
  end

  // Counting the in-flight transfer lets an op retire in its first ISSUE cycle.
  assign taken = taken_q | (v & ~b);

endmodule

// File: rtl/segrw_init_seq.sv
// Segment read/write initiator: turns one burst command into addr/dataW/write
// token triples and forwards returning read data. Option macro: SEGRW_EOS_EN.
module segrw_init_seq
  import segrw_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int LW      = LW_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_v,
  output logic          cmd_b,
  input  logic [AW-1:0] cmd_base,
  input  logic [LW-1:0] cmd_len,
  input  logic          cmd_wr,
  input  logic          wsrc_v,
  input  logic          wsrc_e,
  output logic          wsrc_b,
  input  logic [DW-1:0] wsrc_d,
  output logic          addr_v,
  output logic          addr_e,
  input  logic          addr_b,
  output logic [AW-1:0] addr_d,
  output logic          dataW_v,
  output logic          dataW_e,
  input  logic          dataW_b,
  output logic [DW-1:0] dataW_d,
  output logic          write_v,
  output logic          write_e,
  input  logic          write_b,
  output logic          write_d,
  input  logic          dataR_v,
  input  logic          dataR_e,
  output logic          dataR_b,
  input  logic [DW-1:0] dataR_d,
  output logic          rdo_v,
  output logic          rdo_e,
  input  logic          rdo_b,
  output logic [DW-1:0] rdo_d,
  output logic          done,
  output logic          err
);

  localparam int CW = clog2(MAX_OUT + 1);

`ifdef SEGRW_EOS_EN
  localparam state_e AFTER_LAST = EOS;
`else
  localparam state_e AFTER_LAST = DRAIN;
`endif

  state_e        state;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] rem_q;
  logic          wr_q;
  logic [CW-1:0] outst;

  logic          taken_a, taken_w, taken_k, all_taken;
  logic          wsrc_fire, wsrc_err, credit_ok, load_op, load_eos, retire;
  logic          slot_load;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_write;
  logic          dr_fire, ret_dec, dr_err, iss_inc;

  assign wsrc_b    = reset | !(state == LOAD && wr_q);
  assign wsrc_fire = wsrc_v & ~wsrc_b;
  assign wsrc_err  = wsrc_fire & wsrc_e;
  assign credit_ok = outst < CW'(MAX_OUT);
  assign load_op   = (state == LOAD) && (wr_q ? (wsrc_fire && !wsrc_e) : credit_ok);
  assign all_taken = taken_a & taken_w & taken_k;
  assign retire    = (state == ISSUE) && all_taken;

`ifdef SEGRW_EOS_EN
  assign load_eos = retire && (rem_q == LW'(1));
`else
  assign load_eos = 1'b0;
`endif

  assign slot_load = load_op | load_eos;
  assign ld_addr   = load_eos ? '0 : addr_q;
  assign ld_data   = (load_eos || !wr_q) ? '0 : wsrc_d;
  assign ld_write  = !load_eos && wr_q;

  segrw_tok_slot #(.W(AW)) u_addr (
    .clock(clock), .reset(reset), .load(slot_load), .load_e(load_eos), .load_d(ld_addr),
    .b(addr_b), .v(addr_v), .e(addr_e), .d(addr_d), .taken(taken_a)
  );

  segrw_tok_slot #(.W(DW)) u_dataw (
    .clock(clock), .reset(reset), .load(slot_load), .load_e(load_eos), .load_d(ld_data),
    .b(dataW_b), .v(dataW_v), .e(dataW_e), .d(dataW_d), .taken(taken_w)
  );

  segrw_tok_slot #(.W(1)) u_write (
    .clock(clock), .reset(reset), .load(slot_load), .load_e(load_eos), .load_d(ld_write),
    .b(write_b), .v(write_v), .e(write_e), .d(write_d), .taken(taken_k)
  );

  // Read return path is a zero-latency pass-through; reset only closes it.
  assign dataR_b = reset | rdo_b;
  assign rdo_v   = dataR_v & ~reset;
  assign rdo_e   = dataR_e & ~reset;
  assign rdo_d   = dataR_d;

  assign dr_fire = dataR_v & ~dataR_b;
  assign ret_dec = dr_fire && !dataR_e && (outst != '0);
  assign dr_err  = dr_fire && (dataR_e || (outst == '0));
  assign iss_inc = retire && !wr_q;

  // NOTE: all state below is non-blocking so every branch sees start-of-cycle values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cmd_b  <= 1'b1;
      done   <= 1'b0;
      err    <= 1'b0;
      outst  <= '0;
      addr_q <= '0;
      rem_q  <= '0;
      wr_q   <= 1'b0;
    end else begin
      done <= (state == FIN);
      if (dr_err || wsrc_err) err <= 1'b1;

      case ({iss_inc, ret_dec})
        2'b10:   outst <= outst + CW'(1);
        2'b01:   outst <= outst - CW'(1);
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (cmd_v && !cmd_b) begin
            addr_q <= cmd_base;
            rem_q  <= cmd_len;
            wr_q   <= cmd_wr;
            cmd_b  <= 1'b1;
            state  <= (cmd_len == '0) ? FIN : LOAD;
          end else begin
            cmd_b <= 1'b0;
          end
        end
        LOAD: begin
          if (load_op) state <= ISSUE;
        end
        ISSUE: begin
          if (all_taken) begin
            addr_q <= addr_q + AW'(1);
            rem_q  <= rem_q - LW'(1);
            state  <= (rem_q != LW'(1)) ? LOAD : AFTER_LAST;
          end
        end
`ifdef SEGRW_EOS_EN
        EOS: begin
          if (all_taken) state <= DRAIN;
        end
`endif
        DRAIN: begin
          if (outst == '0) state <= FIN;
        end
        FIN: begin
          state <= IDLE;
          cmd_b <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
